mem_bus_arbiter: RTL

- Two-master, one-slave arbiter that lets two cache controllers share the single line-wide Memory block. Typical masters are the instruction- and data-side caches, or two cache instances.
- Sits between each cache's bus_* port group and the Memory addr/memread/memwrite/wdata/rdata/mem_done port group.
- Uses round-robin arbitration and holds the grant until mem_done.
- Has a one-cycle release turnaround and a hang timeout.

---
 rtl/cache_bus_pkg.sv | 15 +
 rtl/rr_pick2.sv | 19 +
 rtl/mem_bus_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/cache_bus_pkg.sv
// Shared cache/memory bus definitions: default line geometry and the arbiter state encoding.
package cache_bus_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_GNT0 = 4'b0010,
    S_GNT1 = 4'b0100,
    S_REL  = 4'b1000
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the master that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mask_en,
  output logic [1:0] pick
);

  logic [1:0] eligible;

  // Masking the last master keeps a stale request from being re-granted during release
  always_comb begin
    eligible = req;
    if (mask_en) eligible[last] = 1'b0;
    if (eligible == 2'b11) pick = last ? 2'b01 : 2'b10;
    else                   pick = eligible;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of the line-wide Memory, holding the grant until mem_done.
module mem_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_rd,
  input  logic              c0_wr,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_done,
  input  logic              c1_rd,
  input  logic              c1_wr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [1:0]        gnt,
  output logic              err_timeout
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req;
  logic [1:0]       pick;
  logic             req_cur;

  assign req     = {c1_rd | c1_wr, c0_rd | c0_wr};
  assign req_cur = (state == S_GNT1) ? req[1] : req[0];

  rr_pick2 u_pick (
    .req     (req),
    .last    (last),
    .mask_en (state == S_REL),
    .pick    (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last        <= 1'b1;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        S_IDLE, S_REL: begin
          cnt <= '0;
          if      (pick[0]) state <= S_GNT0;
          else if (pick[1]) state <= S_GNT1;
          else              state <= S_IDLE;
        end
        S_GNT0, S_GNT1: begin
          // Completion beats abort, abort beats timeout; only a pure timeout raises the error
          if (mem_done || !req_cur || cnt == LAST_CNT) begin
            state       <= S_REL;
            last        <= (state == S_GNT1);
            err_timeout <= !mem_done && req_cur;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c0_done   = 1'b0;
    c1_done   = 1'b0;
    c0_rdata  = '0;
    c1_rdata  = '0;
    if (state == S_GNT0) begin
      mem_addr  = c0_addr;
      mem_wdata = c0_wdata;
      mem_write = c0_wr;
      mem_read  = c0_rd & ~c0_wr;
      c0_done   = mem_done;
      c0_rdata  = mem_rdata;
    end else if (state == S_GNT1) begin
      mem_addr  = c1_addr;
      mem_wdata = c1_wdata;
      mem_write = c1_wr;
      mem_read  = c1_rd & ~c1_wr;
      c1_done   = mem_done;
      c1_rdata  = mem_rdata;
    end
  end

  assign gnt = {state == S_GNT1, state == S_GNT0};

endmodule
